// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester ports plus the RAM command/return side.
interface ram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              gnt_a;
  logic              rvalid_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_b;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_b;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  ram_rdata,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output busy
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output ram_rdata,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single-port data RAM with in-order read return.
// ARB_FIXED_PRIO_EN: port A always wins ties (default is round-robin).
module ram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         reset,
  ram_arbiter_if.slave bus
);

  logic              sel_a;
  logic              gnt_a;
  logic              gnt_b;
  logic              xfer;
  logic              win_we;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic [RD_LAT:0]   tag_v_q, tag_v_d;
  logic [RD_LAT:0]   tag_p_q, tag_p_d;

  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

`ifdef ARB_FIXED_PRIO_EN
  assign sel_a = bus.req_a;
`else
  // last_b_q = 1 means B was granted last, so A wins the next tie
  logic last_b_q, last_b_d;

  assign sel_a = bus.req_a & (~bus.req_b | last_b_q);
  assign last_b_d = xfer ? gnt_b : last_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  assign gnt_a = ~reset & sel_a;
  assign gnt_b = ~reset & bus.req_b & ~sel_a;
  assign xfer  = gnt_a | gnt_b;

  always_comb begin
    win_we      = 1'b0;
    ram_en_d    = xfer;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag_v_d     = {tag_v_q[RD_LAT-1:0], 1'b0};
    tag_p_d     = {tag_p_q[RD_LAT-1:0], 1'b0};
    if (gnt_a) begin
      win_we      = bus.we_a;
      ram_addr_d  = bus.addr_a;
      ram_wdata_d = bus.wdata_a;
    end else if (gnt_b) begin
      win_we      = bus.we_b;
      ram_addr_d  = bus.addr_b;
      ram_wdata_d = bus.wdata_b;
    end
    ram_we_d   = xfer & win_we;
    tag_v_d[0] = xfer & ~win_we;
    tag_p_d[0] = gnt_b;
  end

  // Oldest tag lines up with the cycle ram_rdata is valid
  always_comb begin
    rvalid_a_d = tag_v_q[RD_LAT] & ~tag_p_q[RD_LAT];
    rvalid_b_d = tag_v_q[RD_LAT] & tag_p_q[RD_LAT];
    rdata_a_d  = rvalid_a_d ? bus.ram_rdata : rdata_a_q;
    rdata_b_d  = rvalid_b_d ? bus.ram_rdata : rdata_b_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag_v_q     <= '0;
      tag_p_q     <= '0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag_v_q     <= tag_v_d;
      tag_p_q     <= tag_p_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.rvalid_a  = rvalid_a_q;
  assign bus.rvalid_b  = rvalid_b_q;
  assign bus.rdata_a   = rdata_a_q;
  assign bus.rdata_b   = rdata_b_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.busy      = |tag_v_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle synchronous RAM model.
module tb_ram_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem  [0:32767];
  bit            wr_v [0:32767];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      15'h0123: init_val = 16'h5A5A;
      15'h0200: init_val = 16'h1111;
      15'h0100: init_val = 16'hA100;
      15'h0101: init_val = 16'hA101;
      15'h0102: init_val = 16'hA102;
      15'h0400: init_val = 16'hB400;
      15'h0401: init_val = 16'hB401;
      15'h0402: init_val = 16'hB402;
      default:  init_val = {1'b0, a} ^ 16'h3C3C;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr]  <= bus.ram_wdata;
        wr_v[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= wr_v[bus.ram_addr] ? mem[bus.ram_addr]
                                            : init_val(bus.ram_addr);
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  bit            exp_ga  [9] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
  bit            exp_gb  [9] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
  bit            exp_rva [9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
  bit            exp_rvb [9] = '{0, 0, 0, 0, 1, 0, 1, 0, 1};
  logic [15:0]   exp_rda [9] = '{16'h0, 16'h0, 16'h0, 16'hA100, 16'hA100,
                                 16'hA101, 16'hA101, 16'hA102, 16'hA102};
  logic [15:0]   exp_rdb [9] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hB400,
                                 16'hB400, 16'hB401, 16'hB401, 16'hB402};

  initial begin
    reset        = 1'b1;
    bus.req_a    = 1'b1;
    bus.we_a     = 1'b0;
    bus.addr_a   = 15'h0123;
    bus.wdata_a  = 16'h0;
    bus.req_b    = 1'b1;
    bus.we_b     = 1'b0;
    bus.addr_b   = 15'h0200;
    bus.wdata_b  = 16'h0;

    repeat (3) begin
      mid();
      chk1("rst_gnt_a", bus.gnt_a, 1'b0);
      chk1("rst_gnt_b", bus.gnt_b, 1'b0);
      chk1("rst_ram_en", bus.ram_en, 1'b0);
      chk1("rst_ram_we", bus.ram_we, 1'b0);
      chk16("rst_ram_addr", {1'b0, bus.ram_addr}, 16'h0);
      chk16("rst_ram_wdata", bus.ram_wdata, 16'h0);
      chk1("rst_rvalid_a", bus.rvalid_a, 1'b0);
      chk1("rst_rvalid_b", bus.rvalid_b, 1'b0);
      chk16("rst_rdata_a", bus.rdata_a, 16'h0);
      chk16("rst_rdata_b", bus.rdata_b, 16'h0);
      chk1("rst_busy", bus.busy, 1'b0);
    end
    next_cyc();
    reset = 1'b0;

    mid();
    chk1("c0_gnt_a_first_tie", bus.gnt_a, 1'b1);
    chk1("c0_gnt_b", bus.gnt_b, 1'b0);
    chk1("c0_ram_en", bus.ram_en, 1'b0);
    next_cyc();
    bus.req_a = 1'b0;

    mid();
    chk1("c1_gnt_a", bus.gnt_a, 1'b0);
    chk1("c1_gnt_b", bus.gnt_b, 1'b1);
    chk1("c1_ram_en", bus.ram_en, 1'b1);
    chk1("c1_ram_we", bus.ram_we, 1'b0);
    chk16("c1_ram_addr", {1'b0, bus.ram_addr}, 16'h0123);
    chk1("c1_busy", bus.busy, 1'b1);
    next_cyc();
    bus.req_b = 1'b0;

    mid();
    chk1("c2_ram_en", bus.ram_en, 1'b1);
    chk16("c2_ram_addr", {1'b0, bus.ram_addr}, 16'h0200);
    chk1("c2_rvalid_a", bus.rvalid_a, 1'b0);
    next_cyc();

    mid();
    chk1("c3_rvalid_a", bus.rvalid_a, 1'b1);
    chk16("c3_rdata_a", bus.rdata_a, 16'h5A5A);
    chk1("c3_rvalid_b", bus.rvalid_b, 1'b0);
    next_cyc();

    mid();
    chk1("c4_rvalid_b", bus.rvalid_b, 1'b1);
    chk16("c4_rdata_b", bus.rdata_b, 16'h1111);
    chk1("c4_rvalid_a", bus.rvalid_a, 1'b0);
    chk16("c4_rdata_a_hold", bus.rdata_a, 16'h5A5A);
    chk1("c4_busy", bus.busy, 1'b0);
    next_cyc();

    mid();
    chk1("c5_ram_en_idle", bus.ram_en, 1'b0);
    chk16("c5_ram_addr_hold", {1'b0, bus.ram_addr}, 16'h0200);
    next_cyc();

    bus.req_a   = 1'b1;
    bus.we_a    = 1'b1;
    bus.addr_a  = 15'h7FFF;
    bus.wdata_a = 16'hBEEF;
    mid();
    chk1("w0_gnt_a", bus.gnt_a, 1'b1);
    next_cyc();
    bus.we_a = 1'b0;

    mid();
    chk1("w1_gnt_a_b2b", bus.gnt_a, 1'b1);
    chk1("w1_ram_en", bus.ram_en, 1'b1);
    chk1("w1_ram_we", bus.ram_we, 1'b1);
    chk16("w1_ram_addr", {1'b0, bus.ram_addr}, 16'h7FFF);
    chk16("w1_ram_wdata", bus.ram_wdata, 16'hBEEF);
    chk1("w1_busy_write", bus.busy, 1'b0);
    next_cyc();
    bus.req_a = 1'b0;

    mid();
    chk1("w2_ram_we", bus.ram_we, 1'b0);
    chk1("w2_ram_en", bus.ram_en, 1'b1);
    next_cyc();

    mid();
    chk1("w3_rvalid_a", bus.rvalid_a, 1'b0);
    chk1("w3_busy", bus.busy, 1'b1);
    next_cyc();

    mid();
    chk1("w4_rvalid_a", bus.rvalid_a, 1'b1);
    chk16("w4_rdata_a_raw", bus.rdata_a, 16'hBEEF);
    chk1("w4_busy", bus.busy, 1'b0);
    next_cyc();

    bus.req_a  = 1'b1;
    bus.we_a   = 1'b0;
    bus.addr_a = 15'h0010;
    mid();
    chk1("r0_gnt_a", bus.gnt_a, 1'b1);
    next_cyc();
    bus.req_a = 1'b0;
    reset     = 1'b1;

    mid();
    chk1("r1_ram_en_cancel", bus.ram_en, 1'b0);
    chk1("r1_busy", bus.busy, 1'b0);
    next_cyc();
    reset = 1'b0;

    for (int i = 2; i <= 5; i++) begin
      mid();
      chk1($sformatf("r%0d_rvalid_a", i), bus.rvalid_a, 1'b0);
      chk1($sformatf("r%0d_busy", i), bus.busy, 1'b0);
      next_cyc();
    end

    for (int k = 0; k < 9; k++) begin
      bus.req_a  = (k < 6);
      bus.req_b  = (k < 6);
      bus.we_a   = 1'b0;
      bus.we_b   = 1'b0;
      bus.addr_a = 15'h0100 + 15'((k + 1) / 2);
      bus.addr_b = 15'h0400 + 15'(k / 2);
      mid();
      chk1($sformatf("k%0d_gnt_a", k), bus.gnt_a, exp_ga[k]);
      chk1($sformatf("k%0d_gnt_b", k), bus.gnt_b, exp_gb[k]);
      chk1($sformatf("k%0d_rvalid_a", k), bus.rvalid_a, exp_rva[k]);
      chk1($sformatf("k%0d_rvalid_b", k), bus.rvalid_b, exp_rvb[k]);
      chk16($sformatf("k%0d_rdata_a", k), bus.rdata_a, exp_rda[k]);
      chk16($sformatf("k%0d_rdata_b", k), bus.rdata_b, exp_rdb[k]);
      next_cyc();
    end

`ifdef ARB_FIXED_PRIO_EN
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk1($sformatf("fp%0d_gnt_a", i), bus.gnt_a, 1'b1);
      chk1($sformatf("fp%0d_gnt_b", i), bus.gnt_b, 1'b0);
      next_cyc();
    end
    bus.req_a = 1'b0;
    #1;
    chk1("fp_drop_gnt_b", bus.gnt_b, 1'b1);
    chk1("fp_drop_gnt_a", bus.gnt_a, 1'b0);
    mid();
    next_cyc();
    bus.req_b = 1'b0;
    repeat (4) next_cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
